// File: rtl/bit_sync_filter_if.sv
// bit_sync_filter_if: raw async levels in, filtered levels and edge strobes out.
interface bit_sync_filter_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;
  modport master (output raw, input sync, rise, fall, any_edge);
  modport slave  (input raw, output sync, rise, fall, any_edge);
endinterface

// File: rtl/bit_sync_filter.sv
// bit_sync_filter: per-channel synchronizer + stability filter + edge strobes.
// Edge registers are built only when BIT_SYNC_EDGE_DET_EN is defined; otherwise tied to 0.
module bit_sync_filter #(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3,
  localparam int CNT_W     = $clog2(FILTER_LEN + 1)
) (
  input logic clk,
  input logic rst_n,
  bit_sync_filter_if.slave bus
);
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] upd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] ff;
    logic [CNT_W-1:0]  cnt;
    logic              f;
    // A level is accepted once it differs from f on FILTER_LEN consecutive edges.
    assign upd[i]  = (ff[STAGES-1] != f) && (cnt == CNT_W'(FILTER_LEN - 1));
    assign filt[i] = f;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ff  <= '0;
        cnt <= '0;
        f   <= 1'b0;
      end else begin
        ff  <= {ff[STAGES-2:0], bus.raw[i]};
        cnt <= (ff[STAGES-1] == f || upd[i]) ? '0 : cnt + CNT_W'(1);
        f   <= upd[i] ? ff[STAGES-1] : f;
      end
  end
  assign bus.sync = filt;
`ifdef BIT_SYNC_EDGE_DET_EN
  // On an update the new level is always the complement of the current one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rise     <= '0;
      bus.fall     <= '0;
      bus.any_edge <= 1'b0;
    end else begin
      bus.rise     <= upd & ~filt;
      bus.fall     <= upd & filt;
      bus.any_edge <= |upd;
    end
`else
  assign bus.rise     = '0;
  assign bus.fall     = '0;
  assign bus.any_edge = 1'b0;
`endif
endmodule

// File: tb/tb_bit_sync_filter.sv
// tb_bit_sync_filter: directed + random stimulus against a sample-history reference model.
module tb_bit_sync_filter;
  localparam int W = 4, S = 2, FL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bit_sync_filter_if #(.WIDTH(W)) bus ();
  bit_sync_filter #(.WIDTH(W), .STAGES(S), .FILTER_LEN(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int tests = 0, fails = 0;
  logic [W-1:0] samp[$];
  logic [W-1:0] qh[$];
  logic [W-1:0] m_sync = '0, m_rise = '0, m_fall = '0;
  logic m_any = 1'b0;
`ifdef BIT_SYNC_EDGE_DET_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    samp.delete();
    qh.delete();
    m_sync = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
  endtask
  // sync_q at an edge is the raw sample taken S edges earlier; the filtered level flips
  // when the last FL sync_q values all disagree with it.
  task automatic model_edge();
    logic [W-1:0] upd;
    bit all;
    samp.push_back(bus.raw);
    qh.push_back(samp.size() > S ? samp[samp.size()-1-S] : '0);
    upd = '0;
    for (int i = 0; i < W; i++) begin
      all = qh.size() >= FL;
      for (int j = 0; j < FL && all; j++)
        if (qh[qh.size()-1-j][i] == m_sync[i]) all = 0;
      upd[i] = all;
    end
    m_rise = EDGE ? (upd & ~m_sync) : '0;
    m_fall = EDGE ? (upd & m_sync) : '0;
    m_any  = |(m_rise | m_fall);
    m_sync = m_sync ^ upd;
  endtask
  task automatic cyc(string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk({tag, ".sync"}, 32'(bus.sync), 32'(m_sync));
    chk({tag, ".rise"}, 32'(bus.rise), 32'(m_rise));
    chk({tag, ".fall"}, 32'(bus.fall), 32'(m_fall));
    chk({tag, ".any"}, 32'(bus.any_edge), 32'(m_any));
  endtask
  task automatic run(string tag, int n);
    for (int k = 0; k < n; k++) cyc(tag);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, ".z_sync"}, 32'(bus.sync), 0);
    chk({tag, ".z_rise"}, 32'(bus.rise), 0);
    chk({tag, ".z_fall"}, 32'(bus.fall), 0);
    chk({tag, ".z_any"}, 32'(bus.any_edge), 0);
  endtask
  int n, nr, nf, nh, ns;
  initial begin
    bus.raw = '0;
    #12 rst_n = 1'b1;
    run("idle", 6);
    bus.raw = 4'hF;
    run("fill", 8);
    chk("fill_level", 32'(bus.sync), 32'hF);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    run("in_rst", 2);
    #3 rst_n = 1'b1;
    n = 0;
    do begin cyc("rel"); n++; end while (bus.sync !== 4'hF && n < 20);
    chk("rel_latency", n, S + FL);
    chk("rel_rise", 32'(bus.rise), EDGE ? 32'hF : 0);
    chk("rel_any", 32'(bus.any_edge), 32'(EDGE));
    cyc("rel_after");
    chk("rel_rise_off", 32'(bus.rise), 0);
    bus.raw = '0;
    run("settle0", 8);
    bus.raw[2] = 1'b1;
    n = 0;
    do begin cyc("lat_r"); n++; end while (bus.sync[2] !== 1'b1 && n < 20);
    chk("lat_rise_n", n, S + FL);
    chk("lat_rise_pulse", 32'(bus.rise[2]), 32'(EDGE));
    cyc("lat_r_after");
    chk("lat_rise_off", 32'(bus.rise[2]), 0);
    run("hold", 3);
    bus.raw[2] = 1'b0;
    n = 0;
    do begin cyc("lat_f"); n++; end while (bus.sync[2] !== 1'b0 && n < 20);
    chk("lat_fall_n", n, S + FL);
    chk("lat_fall_pulse", 32'(bus.fall[2]), 32'(EDGE));
    run("settle1", 4);
    for (int len = 2; len <= 3; len++) begin
      nr = 0; nf = 0; nh = 0;
      bus.raw[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
        if (k == len) bus.raw[0] = 1'b0;
        cyc("glitch");
        nr += int'(bus.rise[0]); nf += int'(bus.fall[0]); nh += int'(bus.sync[0]);
      end
      chk(len == 2 ? "g2_rise" : "g3_rise", nr, len == 3 ? 32'(EDGE) : 0);
      chk(len == 2 ? "g2_fall" : "g3_fall", nf, len == 3 ? 32'(EDGE) : 0);
      chk(len == 2 ? "g2_high" : "g3_high", nh, len == 3 ? 3 : 0);
    end
    nr = 0; n = 0;
    for (int k = 0; k < 6; k++) begin
      bus.raw[1] = (k == 2) ? 1'b0 : 1'b1;
      cyc("restart");
      nh = int'(bus.sync[1]);
      n += nh;
    end
    chk("restart_early", n, 0);
    n = 0;
    do begin cyc("restart_w"); n++; end while (bus.sync[1] !== 1'b1 && n < 20);
    chk("restart_n", n, S);
    bus.raw = 4'b1000;
    run("pre_sim", 8);
    bus.raw = 4'b0101;
    ns = 0;
    for (int k = 0; k < 8; k++) begin
      cyc("simul");
      if (bus.rise === 4'b0101 && bus.fall === 4'b1000 && bus.any_edge === 1'b1) ns++;
    end
    chk("simul_pulse", ns, 32'(EDGE));
    chk("simul_level", 32'(bus.sync), 32'h5);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) bus.raw = bus.raw ^ W'($urandom);
      if (k == 200) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        model_reset();
        cyc("mid_rst_hold");
        #3 rst_n = 1'b1;
      end
      cyc("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
